// File: rtl/async_operator_fifo.sv
// -----------------------------------------------------------------------------
// async_operator_fifo
//
// Dataflow operator node with a multi-reader result queue.
//
// Each input channel fetches one operand token over a req/ack handshake. Once
// every input holds a token and the queue has room, the operator result is
// pushed into a DEPTH-entry queue. Every consumer has its own read pointer, so
// a fast consumer keeps running while a slow one lags. The queue only fills
// when some reader is DEPTH results behind.
//
// Ports
//   clk    in   1                   clock, all state on posedge
//   rst    in   1                   synchronous active-high reset
//   req_l  out  INPUTS              per-input request to upstream producer
//   ack_l  in   INPUTS              upstream ack; din slice valid with it
//   din    in   DATA_WIDTH*INPUTS   operand tokens, slice i = input i
//   req_r  in   OUTPUTS             per-consumer request
//   ack_r  out  OUTPUTS             one-cycle delivery strobe
//   dout   out  DATA_WIDTH*OUTPUTS  delivered result, slice j = consumer j,
//                                   held until the next delivery
//   full   out  1                   some reader has DEPTH unread entries
//   count  out  32                  results pushed since reset (wraps)
//
// Operators
//   INPUTS = 1     : reg | in | out (pass-through), addi | subi | muli (with
//                    IMMEDIATE)
//   INPUTS = 2..3  : add | sub | mul | min | max, folded left to right over
//                    the inputs. All of these are unsigned and modulo
//                    2^DATA_WIDTH. sub is in0 - in1 [- in2].
//   Any name not in these lists behaves as a pass-through of input 0.
// -----------------------------------------------------------------------------
module async_operator_fifo #(
    parameter int          DATA_WIDTH = 32,
    parameter int          INPUTS     = 2,
    parameter int          OUTPUTS    = 2,
    parameter int          DEPTH      = 4,
    parameter string       OP         = "add",
    parameter int unsigned IMMEDIATE  = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic [INPUTS-1:0]              req_l,
    input  logic [INPUTS-1:0]              ack_l,
    input  logic [DATA_WIDTH*INPUTS-1:0]   din,
    input  logic [OUTPUTS-1:0]             req_r,
    output logic [OUTPUTS-1:0]             ack_r,
    output logic [DATA_WIDTH*OUTPUTS-1:0]  dout,
    output logic                           full,
    output logic [31:0]                    count
);

    // The slot address needs at least one bit even for a single-entry queue.
    // Pointers carry one extra wrap bit, so that a full queue and an empty
    // queue have different levels.
    localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              PW        = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0]   DEPTH_LVL = PW'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] IMM = DATA_WIDTH'(IMMEDIATE);

    localparam int SEL_PASS = 0;
    localparam int SEL_ADDI = 1;
    localparam int SEL_SUBI = 2;
    localparam int SEL_MULI = 3;
    localparam int SEL_ADD  = 4;
    localparam int SEL_SUB  = 5;
    localparam int SEL_MUL  = 6;
    localparam int SEL_MIN  = 7;
    localparam int SEL_MAX  = 8;

    localparam int OP_SEL = (OP == "addi") ? SEL_ADDI :
                            (OP == "subi") ? SEL_SUBI :
                            (OP == "muli") ? SEL_MULI :
                            (OP == "add")  ? SEL_ADD  :
                            (OP == "sub")  ? SEL_SUB  :
                            (OP == "mul")  ? SEL_MUL  :
                            (OP == "min")  ? SEL_MIN  :
                            (OP == "max")  ? SEL_MAX  : SEL_PASS;

    genvar gi;

    // -------------------------------------------------------------------------
    // Shared state
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] op_r [INPUTS];     // held operand per input
    logic [INPUTS-1:0]     has_vec;           // operand held per input
    logic [DATA_WIDTH-1:0] op_result;
    logic                  push;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         wr_addr;
    logic [OUTPUTS-1:0]    at_depth;          // reader j has DEPTH unread entries
    logic [31:0]           count_reg;

    // full comes straight from the registered pointers, so it reflects the
    // state before any pop in the current cycle. A push is therefore refused
    // in a full cycle even when a reader frees a slot in that same cycle.
    assign full  = |at_depth;
    assign push  = (&has_vec) && !full;
    assign count = count_reg;

    // -------------------------------------------------------------------------
    // Operator
    // -------------------------------------------------------------------------
    function automatic logic [DATA_WIDTH-1:0] combine(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] r;
        case (OP_SEL)
            SEL_ADD: r = a + b;
            SEL_SUB: r = a - b;
            SEL_MUL: r = a * b;
            SEL_MIN: r = (b < a) ? b : a;
            SEL_MAX: r = (b > a) ? b : a;
            default: r = a;
        endcase
        return r;
    endfunction

    // Left-to-right fold over the inputs: stage gi combines the running value
    // with operand gi.
    generate
        for (gi = 0; gi < INPUTS; gi++) begin : g_fold
            logic [DATA_WIDTH-1:0] acc;
            if (gi == 0) begin : g_first
                assign acc = op_r[0];
            end else begin : g_next
                assign acc = combine(g_fold[gi-1].acc, op_r[gi]);
            end
        end
    endgenerate

    always_comb begin
        case (OP_SEL)
            SEL_ADDI: op_result = op_r[0] + IMM;
            SEL_SUBI: op_result = op_r[0] - IMM;
            SEL_MULI: op_result = op_r[0] * IMM;
            default:  op_result = g_fold[INPUTS-1].acc;
        endcase
    end

    // -------------------------------------------------------------------------
    // Operand gather, one handshake engine per input
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < INPUTS; gi++) begin : g_gather
            logic                  req_reg;
            logic                  has_reg;
            logic                  accept;
            logic [DATA_WIDTH-1:0] op_reg;

            // An ack is taken when the slot is free, or when the slot is
            // emptied by a push in this same cycle. In that second case the
            // new token replaces the one being consumed. An ack that arrives
            // while the slot is busy and no push happens is dropped.
            assign accept = ack_l[gi] && (!has_reg || push);

            always_ff @(posedge clk) begin
                if (rst) begin
                    req_reg <= 1'b0;
                    has_reg <= 1'b0;
                end else if (accept) begin
                    req_reg <= 1'b0;
                    has_reg <= 1'b1;
                end else begin
                    if (push) begin
                        has_reg <= 1'b0;
                    end
                    if (!has_reg && !req_reg) begin
                        req_reg <= 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (accept) begin
                    op_reg <= din[gi*DATA_WIDTH +: DATA_WIDTH];
                end
            end

            assign req_l[gi]   = req_reg;
            assign has_vec[gi] = has_reg;
            assign op_r[gi]    = op_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Result queue write side
    // -------------------------------------------------------------------------
    generate
        if (DEPTH == 1) begin : g_wr_addr_single
            assign wr_addr = '0;
        end else begin : g_wr_addr_multi
            assign wr_addr = wr_ptr_reg[AW-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_addr] <= op_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            count_reg  <= count_reg + 32'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Per-consumer read side
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < OUTPUTS; gi++) begin : g_deliver
            logic [PW-1:0]         rd_ptr_reg;
            logic [PW-1:0]         lvl;
            logic [AW-1:0]         rd_addr;
            logic                  pop;
            logic                  ack_reg;
            logic [DATA_WIDTH-1:0] dout_reg;

            assign lvl          = wr_ptr_reg - rd_ptr_reg;
            assign at_depth[gi] = (lvl == DEPTH_LVL);

            if (DEPTH == 1) begin : g_rd_addr_single
                assign rd_addr = '0;
            end else begin : g_rd_addr_multi
                assign rd_addr = rd_ptr_reg[AW-1:0];
            end

            // No pop is allowed in the cycle that ack_r is high. This gives a
            // maximum of one token per two cycles, and each ack_r pulse lasts
            // exactly one cycle.
            assign pop = req_r[gi] && !ack_reg && (lvl != '0);

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_ptr_reg <= '0;
                    ack_reg    <= 1'b0;
                    dout_reg   <= '0;
                end else begin
                    ack_reg <= pop;
                    if (pop) begin
                        dout_reg   <= mem[rd_addr];
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                end
            end

            assign ack_r[gi]                          = ack_reg;
            assign dout[gi*DATA_WIDTH +: DATA_WIDTH]  = dout_reg;
        end
    endgenerate

endmodule
